// File: rtl/root_req_arbiter.sv
// Two-requester round-robin front end for a shared root engine.
// Optional engine watchdog enabled by defining ROOT_ARB_TIMEOUT_EN.
module root_req_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [19:0] req_data_1,
    input  logic [5:0]  req_data_2,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [19:0] rsp_data,
    output logic        rsp_err,
    output logic        eng_in_valid,
    output logic [9:0]  eng_in_data_1,
    output logic [2:0]  eng_in_data_2,
    input  logic        eng_out_valid,
    input  logic [19:0] eng_out_data,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [9:0]  op1_q, op1_d;
    logic [2:0]  op2_q, op2_d;
    logic [19:0] rsp_data_q, rsp_data_d;
    logic        pick;
    logic        grant_any;
    logic        eng_active;

`ifdef ROOT_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wd_q, wd_d;
    logic       rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign rsp_err = 1'b0;
`endif

    // Round-robin pick: the requester not granted last time wins ties
    always_comb begin
        pick = 1'b0;
        if (req_valid[~last_q]) begin
            pick = ~last_q;
        end else if (req_valid[last_q]) begin
            pick = last_q;
        end
        grant_any = (state_q == ST_IDLE) && (|req_valid) && !rst;
    end

    assign req_ready     = grant_any ? (2'b01 << pick) : 2'b00;
    assign rsp_valid     = (state_q == ST_RESP) ? (2'b01 << gnt_q) : 2'b00;
    assign eng_in_valid  = (state_q == ST_ISSUE);
    assign eng_active    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign eng_in_data_1 = eng_active ? op1_q : 10'd0;
    assign eng_in_data_2 = eng_active ? op2_q : 3'd0;
    assign rsp_data      = rsp_data_q;
    assign busy          = (state_q != ST_IDLE);

    // Next-state and datapath update for the single outstanding request
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rsp_data_d = rsp_data_q;
`ifdef ROOT_ARB_TIMEOUT_EN
        wd_d       = wd_q;
        rsp_err_d  = rsp_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    op1_d   = pick ? req_data_1[19:10] : req_data_1[9:0];
                    op2_d   = pick ? req_data_2[5:3] : req_data_2[2:0];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef ROOT_ARB_TIMEOUT_EN
                wd_d    = 8'd0;
`endif
            end
            ST_WAIT: begin
                if (eng_out_valid) begin
                    rsp_data_d = eng_out_data;
                    state_d    = ST_RESP;
`ifdef ROOT_ARB_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
                end else if (wd_q == TMO_LAST) begin
                    rsp_data_d = 20'd0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    wd_d = wd_q + 8'd1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            op1_q      <= 10'd0;
            op2_q      <= 3'd0;
            rsp_data_q <= 20'd0;
`ifdef ROOT_ARB_TIMEOUT_EN
            wd_q       <= 8'd0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            rsp_data_q <= rsp_data_d;
`ifdef ROOT_ARB_TIMEOUT_EN
            wd_q       <= wd_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_root_req_arbiter.sv
// Directed bench for root_req_arbiter with a stubbed root engine.
// Engine results come from a hand-written lookup of known roots.
module tb_root_req_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [19:0] req_data_1 = 20'd0;
    logic [5:0]  req_data_2 = 6'd0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [19:0] rsp_data;
    logic        rsp_err;
    logic        eng_in_valid;
    logic [9:0]  eng_in_data_1;
    logic [2:0]  eng_in_data_2;
    logic        eng_out_valid;
    logic [19:0] eng_out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic        stub_vld = 1'b0;
    logic        stub_busy = 1'b0;
    logic        stray_vld = 1'b0;
    logic        eng_hang = 1'b0;
    logic [19:0] stub_data = 20'd0;
    logic [9:0]  stub_a = 10'd0;
    logic [2:0]  stub_n = 3'd0;
    int          stub_cnt = 0;
    int          issue_cnt = 0;

    assign eng_out_valid = stub_vld | stray_vld;
    assign eng_out_data  = stub_data;

    root_req_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data_1   (req_data_1),
        .req_data_2   (req_data_2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .eng_in_valid (eng_in_valid),
        .eng_in_data_1(eng_in_data_1),
        .eng_in_data_2(eng_in_data_2),
        .eng_out_valid(eng_out_valid),
        .eng_out_data (eng_out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] root_tab(input logic [9:0] a,
                                             input logic [2:0] n);
        if (a == 10'd16 && n == 3'd2) return 20'h01000;
        if (a == 10'd27 && n == 3'd3) return 20'h00C00;
        if (a == 10'd4 && n == 3'd2) return 20'h00800;
        return 20'h00001;
    endfunction

    // Engine stub: result three cycles after the start pulse
    always @(posedge clk) begin
        stub_vld <= 1'b0;
        if (eng_in_valid) issue_cnt <= issue_cnt + 1;
        if (rst) begin
            stub_busy <= 1'b0;
        end else if (eng_in_valid) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 3;
            stub_a    <= eng_in_data_1;
            stub_n    <= eng_in_data_2;
        end else if (stub_busy && !eng_hang) begin
            if (stub_cnt == 1) begin
                stub_vld  <= 1'b1;
                stub_data <= root_tab(stub_a, stub_n);
                stub_busy <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rsp_valid != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_ack(input logic [1:0] m);
        rsp_ready = m;
        tick();
        rsp_ready = 2'b00;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 00", req_ready);
        end
        checks++;
        if ({busy, rsp_valid, rsp_err, eng_in_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000",
                     {busy, rsp_valid, rsp_err, eng_in_valid});
        end
        checks++;
        if ({rsp_data, eng_in_data_1, eng_in_data_2} !== 33'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0",
                     {rsp_data, eng_in_data_1, eng_in_data_2});
        end
        req_valid = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int c0;
        req_valid  = 2'b01;
        req_data_1 = {10'd0, 10'd16};
        req_data_2 = {3'd0, 3'd2};
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant got %b want 01", req_ready);
        end
        c0 = issue_cnt;
        tick();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({req_ready, eng_in_valid, busy} !== 4'b0011) begin
            errors++;
            $display("FAIL single_issue got %b want 0011",
                     {req_ready, eng_in_valid, busy});
        end
        checks++;
        if ({eng_in_data_1, eng_in_data_2} !== {10'd16, 3'd2}) begin
            errors++;
            $display("FAIL single_ops got %0d/%0d want 16/2",
                     eng_in_data_1, eng_in_data_2);
        end
        tick();
        checks++;
        if ({eng_in_valid, eng_in_data_1} !== {1'b0, 10'd16}) begin
            errors++;
            $display("FAIL single_wait got %b/%0d want 0/16",
                     eng_in_valid, eng_in_data_1);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_valid !== 2'b01 || rsp_data !== 20'h01000) begin
            errors++;
            $display("FAIL single_rsp got %b/%h want 01/01000",
                     rsp_valid, rsp_data);
        end
        checks++;
        if ({rsp_err, eng_in_data_1} !== 11'd0) begin
            errors++;
            $display("FAIL single_rsp_side got %b/%0d want 0/0",
                     rsp_err, eng_in_data_1);
        end
        checks++;
        if (issue_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL single_issue_cnt got %0d want 1", issue_cnt - c0);
        end
        do_ack(2'b01);
        checks++;
        if ({busy, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL single_idle got %b want 000", {busy, rsp_valid});
        end
    endtask

    task automatic test_contention();
        bit ok;
        rst = 1'b1;
        req_valid  = 2'b11;
        req_data_1 = {10'd4, 10'd27};
        req_data_2 = {3'd2, 3'd3};
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL cont_first got %b want 01", req_ready);
        end
        tick();
        req_valid = 2'b10;
        #1;
        checks++;
        if ({req_ready, eng_in_data_1, eng_in_data_2} !==
            {2'b00, 10'd27, 3'd3}) begin
            errors++;
            $display("FAIL cont_issue0 got %b/%0d/%0d want 00/27/3",
                     req_ready, eng_in_data_1, eng_in_data_2);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_valid !== 2'b01 || rsp_data !== 20'h00C00 ||
            req_ready !== 2'b00) begin
            errors++;
            $display("FAIL cont_rsp0 got %b/%h/%b want 01/00c00/00",
                     rsp_valid, rsp_data, req_ready);
        end
        do_ack(2'b01);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL cont_second got %b want 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({eng_in_data_1, eng_in_data_2} !== {10'd4, 3'd2}) begin
            errors++;
            $display("FAIL cont_issue1 got %0d/%0d want 4/2",
                     eng_in_data_1, eng_in_data_2);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_valid !== 2'b10 || rsp_data !== 20'h00800) begin
            errors++;
            $display("FAIL cont_rsp1 got %b/%h want 10/00800",
                     rsp_valid, rsp_data);
        end
        do_ack(2'b10);
    endtask

    task automatic test_fairness();
        bit ok;
        bit found;
        logic [1:0]  exp_g;
        logic [19:0] exp_d;
        req_valid  = 2'b11;
        req_data_1 = {10'd4, 10'd16};
        req_data_2 = {3'd2, 3'd2};
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_d = (k % 2 == 1) ? 20'h00800 : 20'h01000;
            found = 1'b0;
            for (int j = 0; j < 20; j++) begin
                if (req_ready != 2'b00) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            checks++;
            if (!found || req_ready !== exp_g) begin
                errors++;
                $display("FAIL fair_grant%0d got %b want %b",
                         k, req_ready, exp_g);
            end
            wait_rsp(ok);
            checks++;
            if (!ok || rsp_valid !== exp_g || rsp_data !== exp_d) begin
                errors++;
                $display("FAIL fair_rsp%0d got %b/%h want %b/%h",
                         k, rsp_valid, rsp_data, exp_g, exp_d);
            end
            do_ack(rsp_valid);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        req_valid  = 2'b01;
        req_data_1 = {10'd4, 10'd27};
        req_data_2 = {3'd2, 3'd3};
        tick();
        req_valid = 2'b10;
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_valid !== 2'b01 || rsp_data !== 20'h00C00) begin
            errors++;
            $display("FAIL bp_rsp got %b/%h want 01/00c00",
                     rsp_valid, rsp_data);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({rsp_valid, rsp_data, req_ready} !==
                {2'b01, 20'h00C00, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d got %b/%h/%b want 01/00c00/00",
                         i, rsp_valid, rsp_data, req_ready);
            end
        end
        do_ack(2'b01);
        checks++;
        if ({busy, req_ready} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release got %b want 010", {busy, req_ready});
        end
        tick();
        req_valid = 2'b00;
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_valid !== 2'b10 || rsp_data !== 20'h00800) begin
            errors++;
            $display("FAIL bp_next got %b/%h want 10/00800",
                     rsp_valid, rsp_data);
        end
        do_ack(2'b10);
    endtask

    task automatic test_ignore_and_drop();
        bit ok;
        stray_vld = 1'b1;
        tick();
        stray_vld = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, rsp_data} !== {3'b000, 20'h00800}) begin
            errors++;
            $display("FAIL stray got %b/%b/%h want 0/00/00800",
                     busy, rsp_valid, rsp_data);
        end
        req_valid  = 2'b01;
        req_data_1 = {10'd4, 10'd16};
        req_data_2 = {3'd2, 3'd2};
        tick();
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL drop_busy_ready got %b want 00", req_ready);
        end
        tick();
        req_valid = 2'b00;
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_valid !== 2'b01 || rsp_data !== 20'h01000) begin
            errors++;
            $display("FAIL drop_rsp got %b/%h want 01/01000",
                     rsp_valid, rsp_data);
        end
        do_ack(2'b01);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy, req_ready} !== 3'b000) begin
                errors++;
                $display("FAIL drop_idle%0d got %b want 000",
                         i, {busy, req_ready});
            end
        end
    endtask

    task automatic test_order0();
        bit ok;
        req_valid  = 2'b01;
        req_data_1 = {10'd0, 10'd5};
        req_data_2 = {3'd0, 3'd0};
        tick();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({eng_in_valid, eng_in_data_1, eng_in_data_2} !==
            {1'b1, 10'd5, 3'd0}) begin
            errors++;
            $display("FAIL order0_ops got %b/%0d/%0d want 1/5/0",
                     eng_in_valid, eng_in_data_1, eng_in_data_2);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_valid !== 2'b01 || rsp_data !== 20'h00001) begin
            errors++;
            $display("FAIL order0_rsp got %b/%h want 01/00001",
                     rsp_valid, rsp_data);
        end
        do_ack(2'b01);
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit seen;
        req_valid  = 2'b10;
        req_data_1 = {10'd4, 10'd0};
        req_data_2 = {3'd2, 3'd0};
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if ({busy, rsp_valid, eng_in_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_wait got %b want 1000",
                     {busy, rsp_valid, eng_in_valid});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, rsp_valid, rsp_err, eng_in_valid, req_ready} !== 7'd0 ||
            {rsp_data, eng_in_data_1, eng_in_data_2} !== 33'd0) begin
            errors++;
            $display("FAIL mid_reset got %b/%h want 0/0",
                     {busy, rsp_valid, rsp_err, eng_in_valid, req_ready},
                     {rsp_data, eng_in_data_1, eng_in_data_2});
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid != 2'b00) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_rsp got %b want 0", seen);
        end
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL mid_regrant got %b want 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_valid !== 2'b10 || rsp_data !== 20'h00800) begin
            errors++;
            $display("FAIL mid_rsp got %b/%h want 10/00800",
                     rsp_valid, rsp_data);
        end
        do_ack(2'b10);
    endtask

`ifdef ROOT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        eng_hang   = 1'b1;
        req_valid  = 2'b01;
        req_data_1 = {10'd0, 10'd16};
        req_data_2 = {3'd0, 3'd2};
        tick();
        req_valid = 2'b00;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid != 2'b00) break;
            n++;
        end
        checks++;
        if (n !== TMO) begin
            errors++;
            $display("FAIL tmo_cycles got %0d want %0d", n, TMO);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b1, 20'd0}) begin
            errors++;
            $display("FAIL tmo_rsp got %b/%b/%h want 01/1/00000",
                     rsp_valid, rsp_err, rsp_data);
        end
        do_ack(2'b01);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout reached want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_ignore_and_drop();
        test_order0();
        test_mid_reset();
`ifdef ROOT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
